// File: rtl/alu_seq_pkg.sv
// ============================================================================
// alu_seq_pkg : shared widths, opcodes and state encoding for alu_seq_ctrl
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam int DW  = 8;
    localparam int AW  = 2;
    localparam int OPW = 3;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDA  = 3'd1,
        RDB  = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
// ============================================================================
// alu_seq_ctrl : micro-sequencer running one read-read-execute-write ALU
//                command (or a load-immediate) per handshake
// Revision     : 1.0
// ============================================================================
`default_nettype none

module alu_seq_ctrl #(
    parameter int DW        = alu_seq_pkg::DW,
    parameter int AW        = alu_seq_pkg::AW,
    parameter int OPW       = alu_seq_pkg::OPW,
    parameter int RF_RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid_i,
    output logic           cmd_ready_o,
    input  logic           cmd_ld_i,
    input  logic [OPW-1:0] cmd_op_i,
    input  logic [AW-1:0]  cmd_dst_i,
    input  logic [AW-1:0]  cmd_sa_i,
    input  logic [AW-1:0]  cmd_sb_i,
    input  logic [DW-1:0]  cmd_imm_i,
    output logic [AW-1:0]  rf_addr_o,
    output logic           rf_rd_o,
    output logic           rf_wr_o,
    output logic [DW-1:0]  rf_wdata_o,
    input  logic [DW-1:0]  rf_rdata_i,
    output logic [OPW-1:0] alu_op_o,
    output logic [DW-1:0]  alu_a_o,
    output logic [DW-1:0]  alu_b_o,
    input  logic [DW-1:0]  alu_y_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [DW-1:0]  result_o
);
    import alu_seq_pkg::*;

    localparam int CW = (RF_RD_LAT > 1) ? $clog2(RF_RD_LAT) : 1;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  sa_q, sb_q, dst_q;
    logic [OPW-1:0] op_q;

    logic           cmd_acc;
    logic           rd_last;
    logic [AW-1:0]  sa_d, sb_d, dst_d;

    logic           ready_d, rd_d, wr_d, busy_d, done_d;
    logic [AW-1:0]  addr_d;
    logic [DW-1:0]  wdata_d, alu_a_d, alu_b_d, result_d;
    logic [OPW-1:0] alu_op_d;

    assign cmd_acc = cmd_valid_i & cmd_ready_o;
    assign rd_last = (cnt_q == CW'(RF_RD_LAT - 1));

    // Fields seen through the accept edge so the first address is issued with it
    assign sa_d  = cmd_acc ? cmd_sa_i  : sa_q;
    assign sb_d  = cmd_acc ? cmd_sb_i  : sb_q;
    assign dst_d = cmd_acc ? cmd_dst_i : dst_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            dst_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dst_q   <= dst_d;
            if (cmd_acc) begin
                op_q <= cmd_op_i;
            end
        end
    end

    // Wait counter restarts at zero on every read-state entry
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    state_d = cmd_ld_i ? WB : RDA;
                end
            end
            RDA: begin
                if (rd_last) state_d = RDB;
                else         cnt_d   = cnt_q + CW'(1);
            end
            RDB: begin
                if (rd_last) state_d = EXEC;
                else         cnt_d   = cnt_q + CW'(1);
            end
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_d  = (state_d == IDLE);
        busy_d   = (state_d != IDLE);
        rd_d     = (state_d == RDA) || (state_d == RDB);
        wr_d     = (state_d == WB);
        done_d   = (state_d == WB);
        addr_d   = '0;
        wdata_d  = rf_wdata_o;
        alu_a_d  = alu_a_o;
        alu_b_d  = alu_b_o;
        alu_op_d = alu_op_o;
        result_d = result_o;
        case (state_d)
            RDA:     addr_d = sa_d;
            RDB:     addr_d = sb_d;
            WB:      addr_d = dst_d;
            default: addr_d = '0;
        endcase
        if (cmd_acc && cmd_ld_i) begin
            wdata_d = cmd_imm_i;
        end else if (state_q == EXEC) begin
            wdata_d = alu_y_i;
        end
        if (state_q == RDA && rd_last) begin
            alu_a_d = rf_rdata_i;
        end
        if (state_q == RDB && rd_last) begin
            alu_b_d  = rf_rdata_i;
            alu_op_d = op_q;
        end
        if (state_q == WB) begin
            result_d = rf_wdata_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b0;
            rf_rd_o     <= 1'b0;
            rf_wr_o     <= 1'b0;
            done_o      <= 1'b0;
            rf_addr_o   <= '0;
            rf_wdata_o  <= '0;
            alu_a_o     <= '0;
            alu_b_o     <= '0;
            alu_op_o    <= '0;
            result_o    <= '0;
        end else begin
            cmd_ready_o <= ready_d;
            busy_o      <= busy_d;
            rf_rd_o     <= rd_d;
            rf_wr_o     <= wr_d;
            done_o      <= done_d;
            rf_addr_o   <= addr_d;
            rf_wdata_o  <= wdata_d;
            alu_a_o     <= alu_a_d;
            alu_b_o     <= alu_b_d;
            alu_op_o    <= alu_op_d;
            result_o    <= result_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ============================================================================
// tb_alu_seq_ctrl : directed plus random command checks on two instances
//                   (read latency 1 and 2), each with its own register file
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid [2];
    logic       cmd_ready [2];
    logic       rf_rd     [2];
    logic       rf_wr     [2];
    logic       busy      [2];
    logic       done      [2];
    logic [1:0] rf_addr   [2];
    logic [7:0] rf_wdata  [2];
    logic [7:0] rf_rdata  [2];
    logic [7:0] alu_a     [2];
    logic [7:0] alu_b     [2];
    logic [7:0] alu_y     [2];
    logic [7:0] result    [2];
    logic [2:0] alu_op    [2];

    logic       cmd_ld;
    logic [2:0] cmd_op;
    logic [1:0] cmd_dst, cmd_sa, cmd_sb;
    logic [7:0] cmd_imm;

    logic [7:0] regs [2][4];
    logic [7:0] mdl  [2][4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a;
            3'd6:    return b;
            default: return ~a;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rf_wr[d]) regs[d][rf_addr[d]] <= rf_wdata[d];
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            rf_rdata[d] = rf_rd[d] ? regs[d][rf_addr[d]] : 8'h00;
            alu_y[d]    = alu_f(alu_op[d], alu_a[d], alu_b[d]);
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_seq_ctrl #(.DW(8), .AW(2), .OPW(3), .RF_RD_LAT(g + 1)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .cmd_valid_i(cmd_valid[g]),
            .cmd_ready_o(cmd_ready[g]),
            .cmd_ld_i   (cmd_ld),
            .cmd_op_i   (cmd_op),
            .cmd_dst_i  (cmd_dst),
            .cmd_sa_i   (cmd_sa),
            .cmd_sb_i   (cmd_sb),
            .cmd_imm_i  (cmd_imm),
            .rf_addr_o  (rf_addr[g]),
            .rf_rd_o    (rf_rd[g]),
            .rf_wr_o    (rf_wr[g]),
            .rf_wdata_o (rf_wdata[g]),
            .rf_rdata_i (rf_rdata[g]),
            .alu_op_o   (alu_op[g]),
            .alu_a_o    (alu_a[g]),
            .alu_b_o    (alu_b[g]),
            .alu_y_i    (alu_y[g]),
            .busy_o     (busy[g]),
            .done_o     (done[g]),
            .result_o   (result[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command end to end on instance d; poke re-asserts cmd_valid mid-operation
    task automatic exec_cmd(input int d, input bit ld, input logic [2:0] op, input logic [1:0] dst,
                            input logic [1:0] sa, input logic [1:0] sb, input logic [7:0] imm,
                            input bit poke);
        int         n;
        int         lat;
        int         lat_n;
        logic [7:0] exp_v;
        logic [1:0] rd_addr[$];
        lat_n = ld ? 1 : 2 * (d + 1) + 2;
        exp_v = ld ? imm : alu_f(op, mdl[d][sa], mdl[d][sb]);
        @(negedge clk);
        cmd_ld = ld; cmd_op = op; cmd_dst = dst; cmd_sa = sa; cmd_sb = sb; cmd_imm = imm;
        cmd_valid[d] = 1'b1;
        n = 0;
        while (!cmd_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", cmd_ready[d], 1);
        @(negedge clk);
        cmd_valid[d] = 1'b0;
        lat = 1;
        while (!rf_wr[d] && lat < 20) begin
            if (rf_rd[d]) rd_addr.push_back(rf_addr[d]);
            if (poke && lat == 2) begin
                check("ready_mid_op", cmd_ready[d], 0);
                cmd_valid[d] = 1'b1; cmd_ld = 1'b1; cmd_dst = ~dst; cmd_imm = 8'($urandom);
            end
            if (poke && lat == 3) cmd_valid[d] = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("wb_latency", lat, lat_n);
        check("wb_addr", rf_addr[d], dst);
        check("wb_wdata", rf_wdata[d], exp_v);
        check("wb_done", done[d], 1);
        check("rd_wr_excl", rf_rd[d] & rf_wr[d], 0);
        if (!ld) begin
            check("rd_count", rd_addr.size(), 2 * (d + 1));
            foreach (rd_addr[i]) check("rd_addr", rd_addr[i], (i < d + 1) ? sa : sb);
            check("alu_op", alu_op[d], op);
            check("alu_a", alu_a[d], mdl[d][sa]);
            check("alu_b", alu_b[d], mdl[d][sb]);
        end
        mdl[d][dst] = exp_v;
        @(negedge clk);
        check("result", result[d], exp_v);
        check("done_pulse", done[d], 0);
        check("wr_single", rf_wr[d], 0);
        check("idle_ready", cmd_ready[d], 1);
        check("idle_addr", rf_addr[d], 0);
        check("rf_content", regs[d][dst], exp_v);
    endtask

    initial begin
        int         nacc;
        int         ndone;
        int         overlap;
        int         acc_t[2];
        int         wr_seen;
        logic [7:0] exp2;

        rst_n = 1'b0;
        cmd_valid[0] = 1'b0; cmd_valid[1] = 1'b0;
        cmd_ld = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_sa = '0; cmd_sb = '0; cmd_imm = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", cmd_ready[d], 0);
            check("rst_busy", busy[d], 0);
            check("rst_done", done[d], 0);
            check("rst_rd", rf_rd[d], 0);
            check("rst_wr", rf_wr[d], 0);
            check("rst_result", result[d], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check("ready_after_rst", cmd_ready[d], 1);

        // Load the register files, R0=3 R1=2 on both
        for (int d = 0; d < 2; d++) begin
            exec_cmd(d, 1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h03, 1'b0);
            exec_cmd(d, 1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h02, 1'b0);
            exec_cmd(d, 1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'($urandom), 1'b0);
            exec_cmd(d, 1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 8'($urandom), 1'b0);
        end

        exec_cmd(0, 1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0);
        check("add_result", result[0], 8'h05);
        exec_cmd(0, 1'b0, 3'b001, 2'd0, 2'd0, 2'd1, 8'h00, 1'b1);
        check("sub_r0", regs[0][0], 8'h01);

        // Back-to-back with cmd_valid held: R3 += R1 twice
        @(negedge clk);
        cmd_ld = 1'b0; cmd_op = 3'b000; cmd_dst = 2'd3; cmd_sa = 2'd3; cmd_sb = 2'd1;
        cmd_valid[0] = 1'b1;
        exp2 = mdl[0][3] + 8'(2 * mdl[0][1]);
        nacc = 0; ndone = 0; overlap = 0; acc_t[0] = 0; acc_t[1] = 0;
        for (int c = 0; c < 40 && (nacc < 2 || ndone < 2); c++) begin
            if (rf_rd[0] && rf_wr[0]) overlap++;
            if (done[0]) ndone++;
            if (cmd_ready[0] && cmd_valid[0] && nacc < 2) begin
                acc_t[nacc] = c;
                nacc++;
            end
            @(negedge clk);
            if (nacc == 2) cmd_valid[0] = 1'b0;
        end
        check("b2b_accepts", nacc, 2);
        check("b2b_spacing", acc_t[1] - acc_t[0], 5);
        check("b2b_done_count", ndone, 2);
        check("b2b_rd_wr_overlap", overlap, 0);
        check("b2b_result", result[0], exp2);
        check("b2b_rf", regs[0][3], exp2);
        mdl[0][3] = exp2;

        // Reset while in EXEC abandons the write
        @(negedge clk);
        cmd_ld = 1'b0; cmd_op = 3'b000; cmd_dst = 2'd2; cmd_sa = 2'd0; cmd_sb = 2'd1;
        cmd_valid[0] = 1'b1;
        check("pre_accept_ready", cmd_ready[0], 1);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("exec_busy", busy[0], 1);
        check("exec_rd", rf_rd[0], 0);
        check("exec_addr", rf_addr[0], 0);
        check("exec_alu_a", alu_a[0], mdl[0][0]);
        check("exec_alu_b", alu_b[0], mdl[0][1]);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy[0], 0);
        check("async_rst_ready", cmd_ready[0], 0);
        check("async_rst_result", result[0], 0);
        wr_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (rf_wr[0] || done[0]) wr_seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rf_wr[0] || done[0]) wr_seen++;
        end
        check("abandon_no_wr", wr_seen, 0);
        check("abandon_r2", regs[0][2], mdl[0][2]);
        check("ready_after_abandon", cmd_ready[0], 1);

        // Latency-2 instance: 3 + 2 into R2
        exec_cmd(1, 1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0);
        check("lat2_add_result", result[1], 8'h05);

        repeat (24) begin
            exec_cmd(int'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 3'($urandom),
                     2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
